db_arbiter: RTL and testbench

Two-master arbiter for the physical data bus. Master 0 is the CPU_MMU bus port and master 1 is a secondary bus master (DMA or debug port). The arbiter grants one master at a time, muxes its address, write data, access type and length onto the single slave bus, and routes `db_ready` and read data back to the granted master. A per-grant watchdog ends transactions the slave never completes.

---
 rtl/db_arbiter_if.sv | 72 +++++++
 rtl/db_arbiter.sv | 135 +++++++++++++
 tb/tb_db_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/db_arbiter_if.sv
// db_arbiter_if: shared bus types plus the master-side and slave-side bundle of the arbiter.
// Latency: none, declarations only.
// Backpressure: none here; the arbiter holds masters off by withholding mi_ready.
package db_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_NONE  = 2'd0,
    MEM_ACCESS_READ  = 2'd1,
    MEM_ACCESS_WRITE = 2'd2,
    MEM_ACCESS_RMW   = 2'd3
  } MEM_ACCESS_T;

  typedef enum logic [1:0] {
    MEM_LEN_BYTE = 2'd0,
    MEM_LEN_HALF = 2'd1,
    MEM_LEN_WORD = 2'd2
  } MEM_LEN;

endpackage

interface db_arbiter_if;
  import db_arbiter_pkg::*;

  // master 0 (CPU_MMU port)
  logic [31:0] m0_addr;
  logic [31:0] m0_dataOut;
  MEM_ACCESS_T m0_accessType;
  MEM_LEN      m0_memLen;
  logic [31:0] m0_dataIn;
  logic        m0_ready;
  logic        m0_err;

  // master 1 (DMA / debug port)
  logic [31:0] m1_addr;
  logic [31:0] m1_dataOut;
  MEM_ACCESS_T m1_accessType;
  MEM_LEN      m1_memLen;
  logic [31:0] m1_dataIn;
  logic        m1_ready;
  logic        m1_err;

  // slave bus
  logic [31:0] s_addr;
  logic [31:0] s_dataOut;
  MEM_ACCESS_T s_accessType;
  MEM_LEN      s_memLen;
  logic [31:0] s_dataIn;
  logic        s_ready;

  logic [1:0]  gnt;

  // arbiter side
  modport slave (
    input  m0_addr, m0_dataOut, m0_accessType, m0_memLen,
    input  m1_addr, m1_dataOut, m1_accessType, m1_memLen,
    input  s_dataIn, s_ready,
    output m0_dataIn, m0_ready, m0_err,
    output m1_dataIn, m1_ready, m1_err,
    output s_addr, s_dataOut, s_accessType, s_memLen, gnt
  );

  // requester / slave-model side
  modport master (
    output m0_addr, m0_dataOut, m0_accessType, m0_memLen,
    output m1_addr, m1_dataOut, m1_accessType, m1_memLen,
    output s_dataIn, s_ready,
    input  m0_dataIn, m0_ready, m0_err,
    input  m1_dataIn, m1_ready, m1_err,
    input  s_addr, s_dataOut, s_accessType, s_memLen, gnt
  );

endinterface

// File: rtl/db_arbiter.sv
// db_arbiter: two-master data-bus arbiter with per-grant watchdog; ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: grant one cycle after a request is seen in S_IDLE; mi_ready is combinational with s_ready.
// Backpressure: a granted master waits for s_ready or watchdog expiry; losers wait in S_IDLE, one DONE bubble per grant.
module db_arbiter
  import db_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        res,
  db_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req0, req1, sel1, expired, cur_req, in_gnt0, in_gnt1;

  assign req0    = (bus.m0_accessType != MEM_ACCESS_NONE);
  assign req1    = (bus.m1_accessType != MEM_ACCESS_NONE);
  assign in_gnt0 = (state_q == S_GNT0);
  assign in_gnt1 = (state_q == S_GNT1);
  assign cur_req = in_gnt1 ? req1 : req0;
  // Expiry lands on the last allowed grant cycle, so a grant never exceeds TIMEOUT_CYCLES cycles.
  assign expired = WD_EN && (cnt_q == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // On a tie the master that did not own the previous grant wins.
  assign sel1 = req1 && (!req0 || !last_q);
`else
  // Fixed priority: master 1 only when master 0 is not asking.
  assign sel1 = !req0;
`endif

  // Next-state: selection only in S_IDLE; a grant ends only on completion, timeout or abandonment.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = sel1 ? S_GNT1 : S_GNT0;
          gnt_d   = sel1 ? 2'b10 : 2'b01;
          cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = sel1;
`endif
        end
      end
      S_GNT0, S_GNT1: begin
        if (bus.s_ready || expired || !cur_req) begin
          state_d = S_DONE;
          gnt_d   = 2'b00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State, registered grant and watchdog; reset drops any grant immediately.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Slave mux and completion routing; everything idles outside the grant states.
  always_comb begin
    bus.s_addr       = '0;
    bus.s_dataOut    = '0;
    bus.s_accessType = MEM_ACCESS_NONE;
    bus.s_memLen     = MEM_LEN_BYTE;
    bus.m0_ready     = 1'b0;
    bus.m0_err       = 1'b0;
    bus.m1_ready     = 1'b0;
    bus.m1_err       = 1'b0;
    if (in_gnt0) begin
      bus.s_addr       = bus.m0_addr;
      bus.s_dataOut    = bus.m0_dataOut;
      bus.s_accessType = bus.m0_accessType;
      bus.s_memLen     = bus.m0_memLen;
      bus.m0_ready     = bus.s_ready || expired;
      bus.m0_err       = !bus.s_ready && expired;
    end else if (in_gnt1) begin
      bus.s_addr       = bus.m1_addr;
      bus.s_dataOut    = bus.m1_dataOut;
      bus.s_accessType = bus.m1_accessType;
      bus.s_memLen     = bus.m1_memLen;
      bus.m1_ready     = bus.s_ready || expired;
      bus.m1_err       = !bus.s_ready && expired;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.m0_dataIn = bus.s_dataIn;
  assign bus.m1_dataIn = bus.s_dataIn;

endmodule

// File: tb/tb_db_arbiter.sv
// tb_db_arbiter: per-cycle vector table for the arbiter plus reset-mid-grant and disabled-watchdog sequences.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: the slave model is a scripted s_ready per vector.
module tb_db_arbiter;
  import db_arbiter_pkg::*;

  localparam MEM_ACCESS_T N = MEM_ACCESS_NONE;
  localparam MEM_ACCESS_T R = MEM_ACCESS_READ;
  localparam MEM_ACCESS_T W = MEM_ACCESS_WRITE;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'h1111_AAAA;
  localparam logic [31:0] D1 = 32'h2222_BBBB;
  localparam logic [31:0] SD = 32'hCAFE_0123;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0] ALT_G = 2'b10;
`else
  localparam logic [1:0] ALT_G = 2'b01;
`endif

  typedef struct {
    MEM_ACCESS_T a0;
    MEM_ACCESS_T a1;
    logic        rdy;
    logic [1:0]  gnt;
    logic        r0;
    logic        e0;
    logic        r1;
    logic        e1;
  } vec_t;

  logic clk;
  logic res_a;
  logic res_b;
  int   total;
  int   bad;
  vec_t vecs[$];

  db_arbiter_if bus_a();
  db_arbiter_if bus_b();

  db_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_a (
    .clk (clk),
    .res (res_a),
    .bus (bus_a)
  );

  db_arbiter #(.TIMEOUT_CYCLES(0), .CNT_W(3)) dut_b (
    .clk (clk),
    .res (res_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic void add(input MEM_ACCESS_T a0, input MEM_ACCESS_T a1, input logic rdy,
                              input logic [1:0] gnt, input logic r0, input logic e0,
                              input logic r1, input logic e1);
    vec_t v;
    v.a0 = a0; v.a1 = a1; v.rdy = rdy; v.gnt = gnt;
    v.r0 = r0; v.e0 = e0; v.r1 = r1; v.e1 = e1;
    vecs.push_back(v);
  endfunction

  initial begin
    vec_t        v;
    MEM_ACCESS_T exp_at;
    logic [31:0] exp_addr;
    logic [31:0] exp_dat;
    MEM_LEN      exp_len;
    int          held;

    total = 0;
    bad   = 0;

    // both masters continuously, one-cycle slave: alternate grants only with round-robin
    add(W, R, 1, 2'b00, 0, 0, 0, 0);
    add(W, R, 1, 2'b01, 1, 0, 0, 0);
    add(W, R, 1, 2'b00, 0, 0, 0, 0);
    add(W, R, 1, 2'b00, 0, 0, 0, 0);
    add(W, R, 1, ALT_G, ALT_G[0], 0, ALT_G[1], 0);
    add(W, R, 1, 2'b00, 0, 0, 0, 0);
    add(W, R, 1, 2'b00, 0, 0, 0, 0);
    add(W, R, 1, 2'b01, 1, 0, 0, 0);
    add(W, R, 1, 2'b00, 0, 0, 0, 0);
    add(W, R, 1, 2'b00, 0, 0, 0, 0);
    add(W, R, 1, ALT_G, ALT_G[0], 0, ALT_G[1], 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    // master 0 abandons after one grant cycle, pending master 1 follows
    add(R, W, 0, 2'b00, 0, 0, 0, 0);
    add(R, W, 0, 2'b01, 0, 0, 0, 0);
    add(N, W, 0, 2'b01, 0, 0, 0, 0);
    add(N, W, 0, 2'b00, 0, 0, 0, 0);
    add(N, W, 0, 2'b00, 0, 0, 0, 0);
    add(N, W, 1, 2'b10, 0, 0, 1, 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    // master 0 alone, slave readies on the third grant cycle; s_ready during DONE is ignored
    add(R, N, 0, 2'b00, 0, 0, 0, 0);
    add(R, N, 0, 2'b01, 0, 0, 0, 0);
    add(R, N, 0, 2'b01, 0, 0, 0, 0);
    add(R, N, 1, 2'b01, 1, 0, 0, 0);
    add(N, N, 1, 2'b00, 0, 0, 0, 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    // master 1, slave never ready: fourth grant cycle ends with ready+err
    add(N, R, 0, 2'b00, 0, 0, 0, 0);
    add(N, R, 0, 2'b10, 0, 0, 0, 0);
    add(N, R, 0, 2'b10, 0, 0, 0, 0);
    add(N, R, 0, 2'b10, 0, 0, 0, 0);
    add(N, R, 0, 2'b10, 0, 0, 1, 1);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    // s_ready in the expiry cycle is a clean completion
    add(R, N, 0, 2'b00, 0, 0, 0, 0);
    add(R, N, 0, 2'b01, 0, 0, 0, 0);
    add(R, N, 0, 2'b01, 0, 0, 0, 0);
    add(R, N, 0, 2'b01, 0, 0, 0, 0);
    add(R, N, 1, 2'b01, 1, 0, 0, 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    add(N, N, 0, 2'b00, 0, 0, 0, 0);
    // master 1 granted ahead of the reset sequence
    add(N, W, 0, 2'b00, 0, 0, 0, 0);
    add(N, W, 0, 2'b10, 0, 0, 0, 0);

    res_a = 1'b1;
    res_b = 1'b1;
    bus_a.m0_addr = A0; bus_a.m0_dataOut = D0; bus_a.m0_memLen = MEM_LEN_WORD; bus_a.m0_accessType = N;
    bus_a.m1_addr = A1; bus_a.m1_dataOut = D1; bus_a.m1_memLen = MEM_LEN_HALF; bus_a.m1_accessType = N;
    bus_a.s_dataIn = SD; bus_a.s_ready = 1'b0;
    bus_b.m0_addr = A0; bus_b.m0_dataOut = D0; bus_b.m0_memLen = MEM_LEN_WORD; bus_b.m0_accessType = R;
    bus_b.m1_addr = A1; bus_b.m1_dataOut = D1; bus_b.m1_memLen = MEM_LEN_HALF; bus_b.m1_accessType = N;
    bus_b.s_dataIn = SD; bus_b.s_ready = 1'b0;

    #2;
    res_a = 1'b0;
    res_b = 1'b0;
    @(negedge clk);
    chk("rst gnt",     32'(bus_a.gnt), 32'd0);
    chk("rst s_at",    32'(bus_a.s_accessType), 32'(N));
    chk("rst s_addr",  bus_a.s_addr, 32'd0);
    chk("rst s_dout",  bus_a.s_dataOut, 32'd0);
    chk("rst s_len",   32'(bus_a.s_memLen), 32'd0);
    chk("rst rdy/err", 32'({bus_a.m0_ready, bus_a.m0_err, bus_a.m1_ready, bus_a.m1_err}), 32'd0);
    res_a = 1'b1;
    res_b = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      bus_a.m0_accessType = v.a0;
      bus_a.m1_accessType = v.a1;
      bus_a.s_ready       = v.rdy;
      @(negedge clk);
      if (v.gnt == 2'b01) begin
        exp_at = v.a0; exp_addr = A0; exp_dat = D0; exp_len = MEM_LEN_WORD;
      end else if (v.gnt == 2'b10) begin
        exp_at = v.a1; exp_addr = A1; exp_dat = D1; exp_len = MEM_LEN_HALF;
      end else begin
        exp_at = N; exp_addr = 32'd0; exp_dat = 32'd0; exp_len = MEM_LEN_BYTE;
      end
      chk($sformatf("v%0d gnt", i),    32'(bus_a.gnt), 32'(v.gnt));
      chk($sformatf("v%0d s_at", i),   32'(bus_a.s_accessType), 32'(exp_at));
      chk($sformatf("v%0d s_addr", i), bus_a.s_addr, exp_addr);
      chk($sformatf("v%0d s_dout", i), bus_a.s_dataOut, exp_dat);
      chk($sformatf("v%0d s_len", i),  32'(bus_a.s_memLen), 32'(exp_len));
      chk($sformatf("v%0d rdy/err", i),
          32'({bus_a.m0_ready, bus_a.m0_err, bus_a.m1_ready, bus_a.m1_err}),
          32'({v.r0, v.e0, v.r1, v.e1}));
      chk($sformatf("v%0d dataIn", i), 32'({bus_a.m0_dataIn ^ SD, bus_a.m1_dataIn ^ SD} != 64'd0), 32'd0);
    end

    // reset asserted mid-cycle while master 1 holds the bus and the slave is busy
    @(posedge clk);
    #3;
    chk("pre-rst gnt", 32'(bus_a.gnt), 32'b10);
    res_a = 1'b0;
    #1;
    chk("arst s_at",  32'(bus_a.s_accessType), 32'(N));
    chk("arst gnt",   32'(bus_a.gnt), 32'd0);
    chk("arst s_addr", bus_a.s_addr, 32'd0);
    chk("arst rdy",   32'({bus_a.m0_ready, bus_a.m0_err, bus_a.m1_ready, bus_a.m1_err}), 32'd0);
    @(negedge clk);
    chk("arst rdy neg", 32'({bus_a.m1_ready, bus_a.m1_err}), 32'd0);
    bus_a.m0_accessType = R;
    bus_a.m1_accessType = W;
    #2;
    res_a = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst tie gnt", 32'(bus_a.gnt), 32'b01);
    chk("post-rst s_at",    32'(bus_a.s_accessType), 32'(R));
    bus_a.s_ready = 1'b1;
    @(negedge clk);
    chk("post-rst m0 rdy/err", 32'({bus_a.m0_ready, bus_a.m0_err, bus_a.m1_ready}), 32'b100);
    @(posedge clk);
    #1;
    bus_a.m0_accessType = N;
    bus_a.m1_accessType = N;
    bus_a.s_ready       = 1'b0;
    @(negedge clk);
    chk("post-rst done gnt", 32'(bus_a.gnt), 32'd0);

    // watchdog disabled: the grant must hold with no ready pulse
    held = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus_b.gnt == 2'b01 && !bus_b.m0_ready && !bus_b.m0_err && bus_b.s_accessType == R)
        held++;
    end
    chk("wd-off hold cycles", 32'(held), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
